// File: rtl/req_gnt_pkg.sv
// Shared types and sizing helpers for the N-way request/grant arbiter.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_GNT_DELAY = 1;
  localparam int DEF_MAX_HOLD  = 8;

  // Width of a counter that must hold every value 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/req_gnt_rr_pick.sv
// Combinational round-robin picker: first eligible requester scanning upward
// from ptr+1, wrapping modulo N_REQ.
module req_gnt_rr_pick
  import req_gnt_pkg::*;
#(
  parameter int  N_REQ = DEF_N_REQ,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [N_REQ-1:0] rot_elig;
  logic [IW-1:0]    rot_idx [N_REQ];

  // Slot gi of the rotated view is the requester gi+1 places after ptr.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot_idx[gi]  = IW'((32'(ptr) + 32'(gi) + 32'd1) % 32'(N_REQ));
    assign rot_elig[gi] = eligible[rot_idx[gi]];
  end

  always_comb begin
    valid = |rot_elig;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_elig[k]) idx = rot_idx[k];
    end
  end

endmodule

// File: rtl/req_gnt_arbiter.sv
// N-way round-robin request/grant arbiter with programmable grant latency,
// bounded grant hold, forced release and per-requester lockout.
module req_gnt_arbiter
  import req_gnt_pkg::*;
#(
  parameter int  N_REQ     = DEF_N_REQ,
  parameter int  GNT_DELAY = DEF_GNT_DELAY,
  parameter int  MAX_HOLD  = DEF_MAX_HOLD,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam int DLY_W  = cnt_width(GNT_DELAY);
  localparam int HOLD_W = cnt_width(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] lockout_q, lockout_d;
  logic             timeout_q, timeout_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] eligible;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             start_grant;
  logic [IW-1:0]    start_idx;

  assign eligible = req & ~lockout_q;

  req_gnt_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_d       = '0;
    timeout_d   = 1'b0;
    dly_cnt_d   = dly_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    start_grant = 1'b0;
    start_idx   = win_q;
    // A requester seen low at this edge is forgiven its lockout.
    lockout_d   = lockout_q & req;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d = pick_idx;
          if (GNT_DELAY == 1) begin
            start_grant = 1'b1;
            start_idx   = pick_idx;
          end else begin
            state_d   = ST_WAIT;
            dly_cnt_d = DLY_W'(GNT_DELAY - 1);
          end
        end
      end
      ST_WAIT: begin
        dly_cnt_d = dly_cnt_q - DLY_W'(1);
        if (!req[win_q]) begin
          state_d = ST_IDLE;
        end else if (dly_cnt_q == DLY_W'(1)) begin
          start_grant = 1'b1;
          start_idx   = win_q;
        end
      end
      ST_GRANT: begin
        if (!req[win_q]) begin
          state_d = ST_RELEASE;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
          state_d          = ST_RELEASE;
          timeout_d        = 1'b1;
          lockout_d[win_q] = 1'b1;
        end else begin
          gnt_d      = gnt_q;
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_grant) begin
      state_d          = ST_GRANT;
      gnt_d            = '0;
      gnt_d[start_idx] = 1'b1;
      gnt_id_d         = start_idx;
      ptr_d            = start_idx;
      hold_cnt_d       = HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      ptr_q      <= IW'(N_REQ - 1);
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      lockout_q  <= '0;
      timeout_q  <= 1'b0;
      dly_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      gnt_q      <= gnt_d;
      lockout_q  <= lockout_d;
      timeout_q  <= timeout_d;
      dly_cnt_q  <= dly_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
